lsu_mem_port: RTL
=================

# lsu_mem_port

Memory-side initiator for the data memory: takes decoded load/store requests from the load/store unit, checks alignment and bounds, and drives the data memory port (address, read/write enables, write data, transfer size). It captures load data and sign- or zero-extends it, then returns a tagged completion to the LSU. It sits between the LSU issue logic and the data memory, pipelined at one request per cycle with valid/ready backpressure on both sides.

## Interface
- TAG_W, 6, width of the request/response tag
- BASE, 32'h8000_0000, first byte address of data memory
- MEM_SIZE, 32768, data memory size in bytes (power of two)

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready at a rising edge
- req_is_store  in  1  0 = load, 1 = store
- req_funct3  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, low-aligned (byte in [7:0], half in [15:0])
- req_tag  in  TAG_W  opaque tag, returned on the response
- flush  in  1  kill in-flight loads
- mem_address  out  32  to data memory address
- mem_write_enable  out  1  to data memory write enable
- mem_read_enable  out  1  to data memory read enable
- mem_write_data  out  32  to data memory write data
- mem_xfer_size  out  4  bytes per access: 1, 2 or 4
- mem_read_data  in  32  from data memory; combinational read, low-aligned
- resp_valid  out  1  completion present
- resp_ready  in  1  completion consumed when resp_valid && resp_ready at an edge
- resp_tag  out  TAG_W  tag of the completed request
- resp_is_store  out  1  completion is for a store
- resp_data  out  32  extended load data; 0 for stores and faulted requests
- resp_exc  out  2  00 ok, 01 misaligned, 10 access fault, 11 illegal funct3

## Operation
- Two stages:
  - S1 is the request register that drives memory.
  - RSP is the response register.
- Size decode: funct3[1:0] of 00 → 1 byte, 01 → 2 bytes, 10 → 4 bytes.
- Illegal funct3 is any of:
  - funct3[1:0] == 11;
  - funct3 == 110;
  - a store with funct3[2] == 1.
- Exception check in S1, priority illegal > misaligned > access fault:
  - misaligned: addr & (size-1) != 0;
  - access fault: addr < BASE or (addr - BASE) + size > MEM_SIZE, computed in 33-bit arithmetic so no wrap.
- S1 drive, when S1 valid, exc == 00, and S1 is advancing this cycle:
  - mem_read_enable = !is_store;
  - mem_write_enable = is_store;
  - mem_address = S1 addr;
  - mem_write_data = S1 wdata;
  - mem_xfer_size = size.
- In all other cycles both enables are 0. Address, data and size still reflect S1 (or 0 after reset).
- A faulted request never enables memory; it still produces a completion with its resp_exc.
- Load extension on capture into RSP:
  - B/H sign-extend bit 7/15;
  - BU/HU zero-extend;
  - W passes through.
- Advance rules:
  - S1 advances when RSP is empty or resp_ready == 1 in the same cycle.
  - req_ready = !S1_valid || S1 advances (combinational).
  - A new request may enter S1 in the same cycle S1 moves to RSP.
- Flush:
  - Clears RSP if it holds a load.
  - Clears S1 if it holds a load, with enables forced 0 that cycle.
  - A request presented with flush is not accepted if it is a load; req_ready still follows the rule above, and the load is dropped.
  - Stores are non-speculative: a store in S1 or RSP is unaffected and still writes and responds.
- Stores write memory exactly once, on the edge at which S1 advances.

## Timing
- Reset, sampled at the edge with rst_n == 0:
  - S1 and RSP invalid;
  - resp_valid = 0, resp_tag = 0, resp_data = 0, resp_exc = 0, resp_is_store = 0;
  - mem enables 0, mem_address = 0, mem_write_data = 0, mem_xfer_size = 4.
- Reset mid-operation drops all in-flight requests; a store in S1 at that edge does not write.
- Latency:
  - request accepted at edge k;
  - memory driven during cycle k..k+1;
  - store write and load capture at edge k+1;
  - resp_valid high after edge k+1.
- Throughput is 1 per cycle with resp_ready held high.
- Backpressure: resp_valid and all resp_* fields hold stable while resp_ready == 0. A full pipeline (S1 and RSP valid, resp_ready == 0) deasserts req_ready and holds both enables at 0.

## Test plan
- Reset, then SW 0x8000_0010 data 0xDEADBEEF tag 3, then LW same address tag 4:
  - one write with xfer_size 4;
  - responses tag 3 store, then tag 4 data 0xDEADBEEF, two cycles after each request.
- After SB 0x8000_0021 data 0x80:
  - LB same address → resp_data 0xFFFF_FF80;
  - LBU → 0x0000_0080;
  - LH 0x8000_0020 → low byte 0x80 in bits [15:8], sign-extended.
- LW 0x8000_0002 → resp_exc 01; LW 0x8000_8000 → 10; SW 0x7FFF_FFFC → 10; funct3 011 → 11. All four with no memory enable and data 0.
- Back-to-back 8 loads with resp_ready low for cycles 3–6:
  - req_ready drops when full;
  - no enable while stalled;
  - all 8 responses in order, fields stable while stalled.
- Flush with a load in S1 and a store in RSP:
  - the load is never responded to and never enabled;
  - the store response is still delivered.
- Assert rst_n low while a store sits in S1 under stall: no memory write, all outputs at reset values next cycle.

Source files
------------

// File: rtl/lsu_mem_port_if.sv
// lsu_mem_port_if: bundles the three handshake/bus groups of the LSU memory port.
//   req_*  : LSU -> port request channel (valid/ready)
//   mem_*  : port -> data memory access (combinational read data back)
//   resp_* : port -> LSU tagged completion channel (valid/ready)
// Modports: slave = the port itself, master = the LSU/memory environment.
interface lsu_mem_port_if #(
  parameter int TAG_W = 6
);
  logic             req_valid;
  logic             req_ready;
  logic             req_is_store;
  logic [2:0]       req_funct3;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic [TAG_W-1:0] req_tag;

  logic [31:0]      mem_address;
  logic             mem_write_enable;
  logic             mem_read_enable;
  logic [31:0]      mem_write_data;
  logic [3:0]       mem_xfer_size;
  logic [31:0]      mem_read_data;

  logic             resp_valid;
  logic             resp_ready;
  logic [TAG_W-1:0] resp_tag;
  logic             resp_is_store;
  logic [31:0]      resp_data;
  logic [1:0]       resp_exc;

  modport slave (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_tag,
    output req_ready,
    output mem_address, mem_write_enable, mem_read_enable, mem_write_data, mem_xfer_size,
    input  mem_read_data,
    output resp_valid, resp_tag, resp_is_store, resp_data, resp_exc,
    input  resp_ready
  );

  modport master (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_tag,
    input  req_ready,
    input  mem_address, mem_write_enable, mem_read_enable, mem_write_data, mem_xfer_size,
    output mem_read_data,
    input  resp_valid, resp_tag, resp_is_store, resp_data, resp_exc,
    output resp_ready
  );
endinterface

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: two-stage memory-side initiator for the LSU.
//   S1  : request register; checks funct3/alignment/bounds and drives memory.
//   RSP : response register; holds the tagged completion with extended load data.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - synchronous active-low reset
//   flush  - kills in-flight (and newly presented) loads; stores are unaffected
//   bus    - lsu_mem_port_if.slave: req_*, mem_*, resp_* groups
module lsu_mem_port #(
  parameter int          TAG_W    = 6,
  parameter logic [31:0] BASE     = 32'h8000_0000,
  parameter int          MEM_SIZE = 32768
) (
  input logic           clk,
  input logic           rst_n,
  input logic           flush,
  lsu_mem_port_if.slave bus
);
  localparam logic [32:0] MEM_LIM = 33'(MEM_SIZE);

  typedef struct packed {
    logic             is_store;
    logic [2:0]       funct3;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             is_store;
    logic [31:0]      data;
    logic [1:0]       exc;
  } rsp_t;

  // funct3 = W after reset so the idle transfer size reads 4
  localparam s1_t S1_RST = '{is_store: 1'b0, funct3: 3'b010, addr: 32'd0, wdata: 32'd0, tag: '0};

  s1_t  s1_q, req_s;
  logic s1_valid;
  rsp_t rsp_q;
  logic rsp_valid;

  logic [3:0]  s1_size;
  logic [1:0]  s1_exc;
  logic        illegal, misaligned, fault;
  logic [32:0] off, lim_chk;
  logic [31:0] ld_ext;
  logic        s1_adv, s1_kill, s1_go, mem_go, accept;

  // Exception decode on the registered request; 33-bit bounds math cannot wrap
  always_comb begin
    case (s1_q.funct3[1:0])
      2'b00:   s1_size = 4'd1;
      2'b01:   s1_size = 4'd2;
      default: s1_size = 4'd4;
    endcase
    illegal    = (s1_q.funct3[1:0] == 2'b11) || (s1_q.funct3 == 3'b110) ||
                 (s1_q.is_store && s1_q.funct3[2]);
    misaligned = (s1_q.addr & {28'd0, s1_size - 4'd1}) != 32'd0;
    off        = {1'b0, s1_q.addr} - {1'b0, BASE};
    lim_chk    = off + {29'd0, s1_size};
    fault      = (s1_q.addr < BASE) || (lim_chk > MEM_LIM);
    if (illegal)         s1_exc = 2'b11;
    else if (misaligned) s1_exc = 2'b01;
    else if (fault)      s1_exc = 2'b10;
    else                 s1_exc = 2'b00;
  end

  // S1 advances whenever RSP can take it; a flushed load leaves S1 without moving on
  assign s1_adv  = s1_valid && (!rsp_valid || bus.resp_ready);
  assign s1_kill = flush && s1_valid && !s1_q.is_store;
  assign s1_go   = s1_adv && !s1_kill;
  // rst_n gate keeps a store sitting in S1 from writing on a reset edge
  assign mem_go  = s1_go && (s1_exc == 2'b00) && rst_n;

  assign bus.req_ready = !s1_valid || s1_adv;
  assign accept        = bus.req_valid && bus.req_ready && !(flush && !bus.req_is_store);

  assign bus.mem_read_enable  = mem_go && !s1_q.is_store;
  assign bus.mem_write_enable = mem_go && s1_q.is_store;
  assign bus.mem_address      = s1_q.addr;
  assign bus.mem_write_data   = s1_q.wdata;
  assign bus.mem_xfer_size    = s1_size;

  always_comb begin
    case (s1_q.funct3)
      3'b000:  ld_ext = {{24{bus.mem_read_data[7]}}, bus.mem_read_data[7:0]};
      3'b001:  ld_ext = {{16{bus.mem_read_data[15]}}, bus.mem_read_data[15:0]};
      3'b100:  ld_ext = {24'd0, bus.mem_read_data[7:0]};
      3'b101:  ld_ext = {16'd0, bus.mem_read_data[15:0]};
      default: ld_ext = bus.mem_read_data;
    endcase
  end

  always_comb begin
    req_s.is_store = bus.req_is_store;
    req_s.funct3   = bus.req_funct3;
    req_s.addr     = bus.req_addr;
    req_s.wdata    = bus.req_wdata;
    req_s.tag      = bus.req_tag;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_q      <= S1_RST;
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
    end else begin
      if (accept)                 begin s1_valid <= 1'b1; s1_q <= req_s; end
      else if (s1_adv || s1_kill) s1_valid <= 1'b0;

      if (s1_go) begin
        rsp_valid      <= 1'b1;
        rsp_q.tag      <= s1_q.tag;
        rsp_q.is_store <= s1_q.is_store;
        rsp_q.exc      <= s1_exc;
        rsp_q.data     <= (!s1_q.is_store && s1_exc == 2'b00) ? ld_ext : 32'd0;
      end else if (rsp_valid && (bus.resp_ready || (flush && !rsp_q.is_store))) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  assign bus.resp_valid    = rsp_valid;
  assign bus.resp_tag      = rsp_q.tag;
  assign bus.resp_is_store = rsp_q.is_store;
  assign bus.resp_data     = rsp_q.data;
  assign bus.resp_exc      = rsp_q.exc;
endmodule
